pwl_batch_decoder: RTL

Expands the sparse 64-bit PWL segment words delivered over DMA (`{x[63:48], slope[47:16], dt[15:1], sb[0]}`) into dense DAC batches of BATCH_SIZE samples, one batch per clock. It is the reading end of the PWL path: the DMA/sparse-BRAM side writes segment words, and this block turns them into the sample stream that fills the dense BRAM or feeds the DAC directly.

---
 rtl/daq_params_pkg.sv | 22 ++
 rtl/pwl_lane_gen.sv | 61 ++++++
 rtl/pwl_batch_decoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/daq_params_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : daq_params_pkg                                               |
// | Description : Shared DAQ constants and the PWL segment word layout.         |
// | Revision    : 1.0 - initial PWL decoder support                            |
// +----------------------------------------------------------------------------+
package daq_params_pkg;

    localparam int SAMPLE_WIDTH   = 16;
    localparam int BATCH_SIZE     = 16;
    localparam int DMA_DATA_WIDTH = 64;
    localparam int PWL_ACC_WIDTH  = 56;

    typedef struct packed {
        logic [15:0] x;
        logic [31:0] slope;
        logic [14:0] dt;
        logic        sb;
    } pwl_word_t;

endpackage
`default_nettype wire

// File: rtl/pwl_lane_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwl_lane_gen                                                 |
// | Description : One ramp lane: (acc + K*slope) >>> 16, wrapped or clamped.    |
// |               PWL_DEC_SATURATE_EN selects clamping to the 16-bit range.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwl_lane_gen
    import daq_params_pkg::*;
#(
    parameter int ACC_WIDTH    = daq_params_pkg::PWL_ACC_WIDTH,
    parameter int SAMPLE_WIDTH = daq_params_pkg::SAMPLE_WIDTH,
    parameter int K            = 0
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [31:0]          slope,
    output logic [SAMPLE_WIDTH-1:0]     sample
);

    localparam int              c_K_BITS = 8;
    localparam logic [7:0]      c_K      = 8'(K);

    logic signed [ACC_WIDTH-1:0] w_slope_ext;
    logic signed [ACC_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_shift;

    assign w_slope_ext = {{(ACC_WIDTH-32){slope[31]}}, slope};

    // K is a constant, so this unrolls to a fixed shift-add tree.
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < c_K_BITS; i++) begin
            if (c_K[i]) begin
                w_prod = w_prod + (w_slope_ext <<< i);
            end
        end
    end

    assign w_sum   = acc + w_prod;
    assign w_shift = w_sum >>> 16;

`ifdef PWL_DEC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] c_MAX = {{(ACC_WIDTH-16){1'b0}}, 16'h7FFF};
    localparam logic signed [ACC_WIDTH-1:0] c_MIN = {{(ACC_WIDTH-16){1'b1}}, 16'h8000};

    always_comb begin
        if (w_shift > c_MAX) begin
            sample = 16'h7FFF;
        end else if (w_shift < c_MIN) begin
            sample = 16'h8000;
        end else begin
            sample = SAMPLE_WIDTH'(w_shift);
        end
    end
`else
    assign sample = SAMPLE_WIDTH'(w_shift);
`endif

endmodule
`default_nettype wire

// File: rtl/pwl_batch_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwl_batch_decoder                                            |
// | Description : Expands sparse PWL segment words into dense sample batches,   |
// |               one batch per clock. PWL_DEC_SATURATE_EN clamps ramp lanes.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwl_batch_decoder
    import daq_params_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = daq_params_pkg::SAMPLE_WIDTH,
    parameter int BATCH_SIZE     = daq_params_pkg::BATCH_SIZE,
    parameter int DMA_DATA_WIDTH = daq_params_pkg::DMA_DATA_WIDTH,
    parameter int ACC_WIDTH      = daq_params_pkg::PWL_ACC_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DMA_DATA_WIDTH-1:0]          s_word,
    input  logic                               s_valid,
    input  logic                               s_last,
    output logic                               s_ready,
    output logic [SAMPLE_WIDTH*BATCH_SIZE-1:0] m_batch,
    output logic                               m_valid,
    output logic                               m_last,
    input  logic                               m_ready,
    output logic                               busy,
    output logic                               seg_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                  r_state;
    logic [14:0]                 r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [31:0]          r_slope;
    logic [15:0]                 r_x;
    logic                        r_sb;
    logic                        r_last;

    pwl_word_t                   w_word;
    logic [14:0]                 w_dt_eff;
    logic signed [ACC_WIDTH-1:0] w_new_acc;
    logic                        w_idle;
    logic                        w_out_free;
    logic                        w_run_load;
    logic                        w_accept;
    logic                        w_idle_acc;
    logic                        w_load;

    logic signed [ACC_WIDTH-1:0] w_cur_acc;
    logic signed [31:0]          w_cur_slope;
    logic [15:0]                 w_cur_x;
    logic                        w_cur_sb;
    logic                        w_cur_last;
    logic [14:0]                 w_cur_cnt;
    logic signed [ACC_WIDTH-1:0] w_step;
    logic [SAMPLE_WIDTH*BATCH_SIZE-1:0] w_batch;

    assign w_word     = s_word;
    assign w_dt_eff   = (w_word.dt == 15'd0) ? 15'd1 : w_word.dt;
    assign w_new_acc  = {{(ACC_WIDTH-32){w_word.x[15]}}, w_word.x, 16'h0000};

    assign w_idle     = (r_state == S_IDLE);
    assign w_out_free = !m_valid || m_ready;
    assign w_run_load = !w_idle && w_out_free;
    assign s_ready    = rst_n && (w_idle || (w_run_load && (r_cnt == 15'd1)));
    assign w_accept   = s_valid && s_ready;
    assign w_idle_acc = w_idle && w_accept;
    // A word taken in IDLE produces its first batch immediately so it shows one cycle later.
    assign w_load     = w_run_load || (w_idle_acc && w_out_free);
    assign busy       = (r_state == S_RUN);

    assign w_cur_acc   = w_idle ? w_new_acc             : r_acc;
    assign w_cur_slope = w_idle ? signed'(w_word.slope) : r_slope;
    assign w_cur_x     = w_idle ? w_word.x              : r_x;
    assign w_cur_sb    = w_idle ? w_word.sb             : r_sb;
    assign w_cur_last  = w_idle ? s_last                : r_last;
    assign w_cur_cnt   = w_idle ? w_dt_eff              : r_cnt;
    assign w_step      = {{(ACC_WIDTH-32){w_cur_slope[31]}}, w_cur_slope} <<< 4;

    for (genvar k = 0; k < BATCH_SIZE; k++) begin : g_lane
        logic [SAMPLE_WIDTH-1:0] w_ramp;

        pwl_lane_gen #(
            .ACC_WIDTH    (ACC_WIDTH),
            .SAMPLE_WIDTH (SAMPLE_WIDTH),
            .K            (k)
        ) u_lane (
            .acc    (w_cur_acc),
            .slope  (w_cur_slope),
            .sample (w_ramp)
        );

        assign w_batch[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = w_cur_sb ? w_cur_x : w_ramp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_slope <= '0;
            r_x     <= '0;
            r_sb    <= 1'b0;
            r_last  <= 1'b0;
            m_batch <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            seg_err <= 1'b0;
        end else begin
            if (w_accept && (w_word.dt == 15'd0)) begin
                seg_err <= 1'b1;
            end

            if (w_load) begin
                m_batch <= w_batch;
                m_valid <= 1'b1;
                m_last  <= w_cur_last && (w_cur_cnt == 15'd1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            if (w_idle_acc) begin
                r_x     <= w_word.x;
                r_slope <= signed'(w_word.slope);
                r_sb    <= w_word.sb;
                r_last  <= s_last;
                if (w_out_free) begin
                    r_acc   <= w_cur_acc + w_step;
                    r_cnt   <= w_dt_eff - 15'd1;
                    r_state <= (w_dt_eff == 15'd1) ? S_IDLE : S_RUN;
                end else begin
                    r_acc   <= w_new_acc;
                    r_cnt   <= w_dt_eff;
                    r_state <= S_RUN;
                end
            end else if (w_run_load) begin
                if (r_cnt == 15'd1) begin
                    if (s_valid) begin
                        r_x     <= w_word.x;
                        r_slope <= signed'(w_word.slope);
                        r_sb    <= w_word.sb;
                        r_last  <= s_last;
                        r_acc   <= w_new_acc;
                        r_cnt   <= w_dt_eff;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end else begin
                    r_acc <= r_acc + w_step;
                    r_cnt <= r_cnt - 15'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
